// File: rtl/cpe142_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpe142_ctrl_pkg
// Brief   : State encoding, control-field encodings and default opcodes for
//           the multi-cycle controller.
// Revision: 1.0 - initial release
// ============================================================================
package cpe142_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_A   = 4'd2,
        S_ALU_WB   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    localparam logic [1:0] c_SRCB_REGB  = 2'b00;
    localparam logic [1:0] c_SRCB_ONE   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_BOFF  = 2'b11;

    localparam logic [1:0] c_ALUOP_ADD  = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB  = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNC = 2'b10;

    localparam logic [1:0] c_PCSRC_ALU  = 2'b00;
    localparam logic [1:0] c_PCSRC_OUT  = 2'b01;
    localparam logic [1:0] c_PCSRC_JMP  = 2'b10;

    localparam logic [1:0] c_BR_LT      = 2'b00;
    localparam logic [1:0] c_BR_GT      = 2'b01;
    localparam logic [1:0] c_BR_EQ      = 2'b10;

    localparam logic [3:0] c_OP_ATYPE   = 4'b0000;
    localparam logic [3:0] c_OP_LW      = 4'b1000;
    localparam logic [3:0] c_OP_SW      = 4'b1011;
    localparam logic [3:0] c_OP_BLT     = 4'b0100;
    localparam logic [3:0] c_OP_BGT     = 4'b0101;
    localparam logic [3:0] c_OP_BEQ     = 4'b0110;
    localparam logic [3:0] c_OP_JMP     = 4'b1100;
    localparam logic [3:0] c_OP_HALT    = 4'b1111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] br_type;
        logic       halted;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_ctrl_out_decode.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_out_decode
// Brief   : Moore mapping from controller state to the datapath control bus.
// Revision: 1.0 - initial release
// ============================================================================
module ctrl_out_decode
    import cpe142_ctrl_pkg::*;
#(
    parameter int                   OPCODE_W = 4,
    parameter logic [OPCODE_W-1:0]  OP_BGT   = c_OP_BGT,
    parameter logic [OPCODE_W-1:0]  OP_BEQ   = c_OP_BEQ
) (
    input  state_t                  i_state,
    input  logic [OPCODE_W-1:0]     i_op,
    input  logic                    i_mem_ready,
    output ctrl_t                   o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = c_SRCB_ONE;
                o_ctrl.alu_op    = c_ALUOP_ADD;
                o_ctrl.pc_source = c_PCSRC_ALU;
                // IR and PC only advance once the instruction word is valid
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = c_SRCB_BOFF;
                o_ctrl.alu_op    = c_ALUOP_ADD;
            end
            S_EXEC_A: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = c_SRCB_REGB;
                o_ctrl.alu_op    = c_ALUOP_FUNC;
            end
            S_ALU_WB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = c_SRCB_IMM;
                o_ctrl.alu_op    = c_ALUOP_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = c_SRCB_REGB;
                o_ctrl.alu_op        = c_ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = c_PCSRC_OUT;
                // only branch opcodes reach this state, so anything else is BLT
                if (i_op == OP_BGT)
                    o_ctrl.br_type = c_BR_GT;
                else if (i_op == OP_BEQ)
                    o_ctrl.br_type = c_BR_EQ;
                else
                    o_ctrl.br_type = c_BR_LT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = c_PCSRC_JMP;
            end
            S_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control
// Brief   : Multi-cycle instruction sequencer with halt, illegal-opcode
//           detection and retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_control
    import cpe142_ctrl_pkg::*;
#(
    parameter int                   OPCODE_W = 4,
    parameter logic [OPCODE_W-1:0]  OP_ATYPE = c_OP_ATYPE,
    parameter logic [OPCODE_W-1:0]  OP_LW    = c_OP_LW,
    parameter logic [OPCODE_W-1:0]  OP_SW    = c_OP_SW,
    parameter logic [OPCODE_W-1:0]  OP_BLT   = c_OP_BLT,
    parameter logic [OPCODE_W-1:0]  OP_BGT   = c_OP_BGT,
    parameter logic [OPCODE_W-1:0]  OP_BEQ   = c_OP_BEQ,
    parameter logic [OPCODE_W-1:0]  OP_JMP   = c_OP_JMP,
    parameter logic [OPCODE_W-1:0]  OP_HALT  = c_OP_HALT,
    parameter int                   CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_W-1:0]     opcode,
    input  logic                    mem_ready,
    output logic                    PCWrite,
    output logic                    PCWriteCond,
    output logic                    IorD,
    output logic                    IRWrite,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    MemtoReg,
    output logic                    RegDst,
    output logic                    RegWrite,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic [1:0]              PCSource,
    output logic [1:0]              BrType,
    output logic                    illegal_op,
    output logic                    halted,
    output logic [CNT_W-1:0]        retired
);

    state_t                 r_state;
    state_t                 w_next;
    logic [OPCODE_W-1:0]    r_op;
    logic                   r_illegal;
    logic [CNT_W-1:0]       r_retired;
    logic                   w_illegal;
    logic                   w_retire;
    ctrl_t                  w_ctrl;

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_ATYPE)
                    w_next = S_EXEC_A;
                else if (opcode == OP_LW || opcode == OP_SW)
                    w_next = S_MEM_ADDR;
                else if (opcode == OP_BLT || opcode == OP_BGT || opcode == OP_BEQ)
                    w_next = S_BRANCH;
                else if (opcode == OP_JMP)
                    w_next = S_JUMP;
                else if (opcode == OP_HALT)
                    w_next = S_HALT;
                else begin
                    w_next    = S_FETCH;
                    w_illegal = 1'b1;
                end
            end
            S_EXEC_A:   w_next = S_ALU_WB;
            S_ALU_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEM_ADDR: w_next = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal;
            if (r_state == S_DECODE)
                r_op <= opcode;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    ctrl_out_decode #(
        .OPCODE_W    (OPCODE_W),
        .OP_BGT      (OP_BGT),
        .OP_BEQ      (OP_BEQ)
    ) u_decode (
        .i_state     (r_state),
        .i_op        (r_op),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.iord;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign BrType      = w_ctrl.br_type;
    assign halted      = w_ctrl.halted;
    assign illegal_op  = r_illegal;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_control
// Brief   : Random instruction stream with random memory stalls and resets,
//           checked against a per-instruction step-list reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       mem_ready = 1'b0;

    logic       a_pcw, a_pcwc, a_iord, a_irw, a_mr, a_mw, a_m2r, a_rd, a_rw, a_sa, a_ill, a_halt;
    logic [1:0] a_sb, a_op, a_ps, a_bt;
    logic [15:0] a_ret;
    logic       b_pcw, b_pcwc, b_iord, b_irw, b_mr, b_mw, b_m2r, b_rd, b_rw, b_sa, b_ill, b_halt;
    logic [1:0] b_sb, b_op, b_ps, b_bt;
    logic [3:0] b_ret;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control u_dut16 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .IRWrite(a_irw),
        .MemRead(a_mr), .MemWrite(a_mw), .MemtoReg(a_m2r), .RegDst(a_rd),
        .RegWrite(a_rw), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_op),
        .PCSource(a_ps), .BrType(a_bt), .illegal_op(a_ill), .halted(a_halt),
        .retired(a_ret)
    );

    multicycle_control #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .IRWrite(b_irw),
        .MemRead(b_mr), .MemWrite(b_mw), .MemtoReg(b_m2r), .RegDst(b_rd),
        .RegWrite(b_rw), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_op),
        .PCSource(b_ps), .BrType(b_bt), .illegal_op(b_ill), .halted(b_halt),
        .retired(b_ret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One expected cycle of an instruction; wt steps repeat until mem_ready
    typedef struct {
        logic [18:0] ctl;
        bit          fetch;
        bit          wt;
        bit          ret;
        bit          ill;
        bit          hlt;
        bit          dec;
        logic [3:0]  op;
    } step_t;

    step_t q[$];

    function automatic logic [18:0] mk(input bit pcw, pcwc, iord, irw, mr, mw, m2r, rd, rw, sa,
                                       input logic [1:0] sb, aop, ps, bt, input bit h);
        return {pcw, pcwc, iord, irw, mr, mw, m2r, rd, rw, sa, sb, aop, ps, bt, h};
    endfunction

    function automatic step_t st(input logic [18:0] ctl, input bit wt, ret);
        step_t s;
        s.ctl = ctl; s.fetch = 0; s.wt = wt; s.ret = ret;
        s.ill = 0; s.hlt = 0; s.dec = 0; s.op = 4'h0;
        return s;
    endfunction

    task automatic push_instr(input logic [3:0] op);
        step_t s;
        s = st(mk(0,0,0,0,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00, 0), 1, 0);
        s.fetch = 1;
        q.push_back(s);
        s = st(mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 2'b00, 0), 0, 0);
        s.dec = 1;
        s.op  = op;
        case (op)
            4'b0000, 4'b1000, 4'b1011, 4'b0100, 4'b0101, 4'b0110, 4'b1100, 4'b1111: ;
            default: s.ill = 1;
        endcase
        q.push_back(s);
        case (op)
            4'b0000: begin
                q.push_back(st(mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 2'b00, 0), 0, 0));
                q.push_back(st(mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0, 1));
            end
            4'b1000: begin
                q.push_back(st(mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 2'b00, 0), 0, 0));
                q.push_back(st(mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1, 0));
                q.push_back(st(mk(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0, 1));
            end
            4'b1011: begin
                q.push_back(st(mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 2'b00, 0), 0, 0));
                q.push_back(st(mk(0,0,1,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1, 1));
            end
            4'b0100: q.push_back(st(mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 2'b00, 0), 0, 1));
            4'b0101: q.push_back(st(mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 2'b01, 0), 0, 1));
            4'b0110: q.push_back(st(mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 2'b10, 0), 0, 1));
            4'b1100: q.push_back(st(mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 2'b00, 0), 0, 1));
            4'b1111: begin
                s = st(mk(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1), 0, 0);
                s.hlt = 1;
                q.push_back(s);
            end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] pick_op();
        logic [3:0] ill_set [8] = '{4'h1, 4'h2, 4'h3, 4'h7, 4'h9, 4'hA, 4'hD, 4'hE};
        int r = int'($urandom % 32);
        if (r < 6)       return 4'b0000;
        else if (r < 11) return 4'b1000;
        else if (r < 15) return 4'b1011;
        else if (r < 18) return 4'b0100;
        else if (r < 21) return 4'b0101;
        else if (r < 24) return 4'b0110;
        else if (r < 27) return 4'b1100;
        else if (r < 31) return ill_set[$urandom % 8];
        else             return 4'b1111;
    endfunction

    initial begin
        step_t       cur;
        logic [18:0] exp_ctl;
        logic [18:0] got16, got4;
        int          exp_ret = 0;
        bit          exp_ill = 0;
        int          halt_cnt = 0;
        bit          do_rst;

        rst_n = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            do_rst = (halt_cnt >= 12) || ($urandom % 150 == 0);
            rst_n  = ~do_rst;
            if (q.size() == 0) push_instr(pick_op());
            cur = q[0];
            mem_ready = ($urandom % 4) != 0;
            opcode    = cur.dec ? cur.op : 4'($urandom);
            #1;
            exp_ctl = cur.ctl;
            if (cur.fetch && mem_ready) exp_ctl = exp_ctl | mk(1,0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            got16 = {a_pcw, a_pcwc, a_iord, a_irw, a_mr, a_mw, a_m2r, a_rd, a_rw, a_sa, a_sb, a_op, a_ps, a_bt, a_halt};
            got4  = {b_pcw, b_pcwc, b_iord, b_irw, b_mr, b_mw, b_m2r, b_rd, b_rw, b_sa, b_sb, b_op, b_ps, b_bt, b_halt};
            check("ctrl16", 32'(got16), 32'(exp_ctl));
            check("ctrl4", 32'(got4), 32'(exp_ctl));
            check("illegal16", 32'(a_ill), 32'(exp_ill));
            check("illegal4", 32'(b_ill), 32'(exp_ill));
            check("retired16", 32'(a_ret), 32'(exp_ret % 65536));
            check("retired4", 32'(b_ret), 32'(exp_ret % 16));

            // advance the model across the coming rising edge
            if (do_rst) begin
                q.delete();
                exp_ret  = 0;
                exp_ill  = 0;
                halt_cnt = 0;
            end else begin
                exp_ill = cur.ill;
                if (cur.hlt) begin
                    halt_cnt++;
                end else if (!cur.wt || mem_ready) begin
                    if (cur.ret) exp_ret++;
                    void'(q.pop_front());
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences every instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives Moore control signals to the datapath (PC, IR, ALU, register file, memory). Memory accesses stall on a ready handshake. It adds a sticky halt, illegal-opcode detection and a retired-instruction counter. It sits between the instruction register and the datapath muxes in the cpe142 CPU top.

Parameters:
OPCODE_W, 4, opcode width taken from IR[15:12]-style field
OP_ATYPE, 4'b0000, register/ALU instruction
OP_LW, 4'b1000, load word
OP_SW, 4'b1011, store word
OP_BLT, 4'b0100, branch if less-than
OP_BGT, 4'b0101, branch if greater-than
OP_BEQ, 4'b0110, branch if equal
OP_JMP, 4'b1100, jump
OP_HALT, 4'b1111, halt
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  OPCODE_W  IR opcode field, sampled in DECODE
mem_ready  in  1  memory completes current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if datapath branch condition true
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
IRWrite  out  1  load IR
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  writeback source is MDR
RegDst  out  1  destination is rd field
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = regA
ALUSrcB  out  2  00 regB, 01 const 1, 10 sign-ext imm, 11 branch offset
ALUOp  out  2  00 add, 01 subtract/compare, 10 funct-decoded
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
BrType  out  2  00 lt, 01 gt, 10 eq (valid when PCWriteCond=1)
illegal_op  out  1  one-cycle pulse on unknown opcode
halted  out  1  sticky halt indicator
retired  out  CNT_W  instructions completed

Behaviour:
- States: FETCH, DECODE, EXEC_A, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT. Encoding lives in the package.
- Control outputs are Moore, decoded from the state register only. Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite assert only when mem_ready=1 (the single qualified exception). The FSM holds in FETCH while mem_ready=0.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - ATYPE goes to EXEC_A.
  - LW and SW go to MEM_ADDR.
  - BLT, BGT and BEQ go to BRANCH.
  - JMP goes to JUMP.
  - HALT goes to HALT.
  - Any other opcode pulses illegal_op for one cycle, goes to FETCH and does not retire.
- EXEC_A: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALU_WB.
- ALU_WB: RegDst=1, RegWrite=1, MemtoReg=0. Retires, then FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEM_RD for LW, MEM_WR for SW. The opcode is latched internally in DECODE.
- MEM_RD: MemRead=1, IorD=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Retires, then FETCH.
- MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready, then retires and goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. BrType is 00/01/10 for BLT/BGT/BEQ. Retires, then FETCH.
- JUMP: PCWrite=1, PCSource=10. Retires, then FETCH.
- HALT: all controls 0, halted=1. Stays until reset; mem_ready and opcode are ignored. The HALT instruction itself does not retire.
- Minimum latency with mem_ready tied to 1:
  - ATYPE 4 cycles.
  - LW 5 cycles.
  - SW 4 cycles.
  - Branch 3 cycles.
  - JMP 3 cycles.
- Each wait cycle on mem_ready adds 1 cycle.
- retired increments by 1 on the clock edge leaving a retiring state. It wraps modulo 2^CNT_W with no saturation.
- Reset (rst_n=0 at a clock edge), regardless of the current state, including mid-wait or HALT:
  - state = FETCH, latched opcode = 0.
  - retired = 0, halted = 0, illegal_op = 0.
  - Outputs therefore read FETCH values: MemRead=1, ALUSrcB=01, PCSource=00, ALUOp=00, all others 0. IRWrite and PCWrite follow mem_ready.
- The opcode input is don't-care outside DECODE.

Decomposition:
- Package cpe142_ctrl_pkg: state typedef/localparams, ALUSrcB/ALUOp/PCSource/BrType encodings, default opcode constants.
- One natural sub-module: ctrl_out_decode, a purely combinational mapping from state, latched opcode and mem_ready to the control bus.
- The FSM, opcode latch and counter stay in multicycle_control.

Test Plan:
1. Reset, then opcode=0000 with mem_ready=1 -> FETCH, DECODE, EXEC_A, ALU_WB; RegWrite=1 and RegDst=1 in cycle 4; retired=1.
2. LW (1000) with mem_ready low for 2 cycles in MEM_RD -> MemRead=1 and IorD=1 held 3 cycles; MEM_WB has MemtoReg=1 and RegWrite=1; total 7 cycles; retired increments.
3. SW, BLT, BGT, BEQ, JMP in sequence -> MemWrite only in MEM_WR; BrType 00/01/10 with PCWriteCond=1; JMP gives PCWrite=1 and PCSource=10; retired=5.
4. Opcode 0010 -> illegal_op=1 for exactly one cycle after DECODE; FSM returns to FETCH; retired unchanged.
5. HALT (1111) -> halted=1, all controls 0 for 10+ cycles despite opcode and mem_ready toggling; then rst_n=0 -> halted=0, state FETCH, retired=0.
6. Reset asserted during a MEM_RD wait -> next edge shows FETCH outputs; MemWrite and RegWrite never assert; CNT_W=4 build wraps retired 15 to 0 after 16 retirements.
